// File: rtl/core_run_pkg.sv
// Shared types and default sizing for the core run sequencer.
package core_run_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam int unsigned DEF_CNT_WIDTH  = 16;
  localparam int unsigned DEF_MAX_CYCLES = 32'h0000_FFFF;

endpackage

// File: rtl/core_run_ctrl.sv
// Run sequencer: pulses core_start, counts RUN cycles until a rising edge of
// core_done or a timeout, then reports the count under a valid/ack handshake.
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  output logic                 busy,
  output logic                 core_start,
  input  logic                 core_done,
  output logic                 result_valid,
  input  logic                 result_ack,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic                 timed_out,
  output logic [7:0]           run_count
);

  localparam logic [CNT_WIDTH-1:0] MAX_C      = CNT_WIDTH'(MAX_CYCLES);
  localparam logic [7:0]           LAST_PHASE = 8'(START_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [7:0]             phase_q, phase_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic                   done_q;
  logic                   done_rise;
  logic [CNT_WIDTH-1:0]   cycle_count_q, cycle_count_d;
  logic                   timed_out_q, timed_out_d;
  logic [7:0]             run_count_q, run_count_d;
  logic                   busy_q, busy_d;
  logic                   core_start_q, core_start_d;
  logic                   result_valid_q, result_valid_d;

  // Next-state, counters, result latching and output decode of the next state
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    cnt_d          = cnt_q;
    cycle_count_d  = cycle_count_q;
    timed_out_d    = timed_out_q;
    run_count_d    = run_count_q;
    cnt_inc        = cnt_q + 1'b1;
    done_rise      = core_done & ~done_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = START;
          phase_d = '0;
          cnt_d   = '0;
        end
      end
      START: begin
        phase_d = phase_q + 8'd1;
        if (phase_q == LAST_PHASE) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A done edge takes priority over a timeout landing on the same cycle.
        if (done_rise) begin
          cycle_count_d = cnt_q;
          timed_out_d   = 1'b0;
          run_count_d   = run_count_q + 8'd1;
          state_d       = REPORT;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == MAX_C) begin
            cycle_count_d = MAX_C;
            timed_out_d   = 1'b1;
            run_count_d   = run_count_q + 8'd1;
            state_d       = REPORT;
          end
        end
      end
      REPORT: begin
        if (result_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered copies of the decoded next state.
    busy_d         = (state_d != IDLE);
    core_start_d   = (state_d == START);
    result_valid_d = (state_d == REPORT);
  end

  // State, counters, done edge register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      phase_q        <= '0;
      cnt_q          <= '0;
      done_q         <= 1'b0;
      cycle_count_q  <= '0;
      timed_out_q    <= 1'b0;
      run_count_q    <= '0;
      busy_q         <= 1'b0;
      core_start_q   <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      done_q         <= core_done;
      cycle_count_q  <= cycle_count_d;
      timed_out_q    <= timed_out_d;
      run_count_q    <= run_count_d;
      busy_q         <= busy_d;
      core_start_q   <= core_start_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy         = busy_q;
  assign core_start   = core_start_q;
  assign result_valid = result_valid_q;
  assign cycle_count  = cycle_count_q;
  assign timed_out    = timed_out_q;
  assign run_count    = run_count_q;

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run sequencer sitting directly upstream of the processor top level. Accepts a run request from the host/testbench side, holds the core in start for a fixed number of cycles, releases it, then counts execution cycles until the core raises done or a timeout expires. It latches the cycle count and completion status and presents them under a valid/ack handshake.

## Interface
Parameters:
- START_CYCLES, 2: cycles core_start is held high per run; legal range 1..255.
- CNT_WIDTH, 16: width of the cycle counter and of cycle_count.
- MAX_CYCLES, 16'hFFFF: timeout limit in RUN cycles; must be ≥1 and fit in CNT_WIDTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  1  host run request; sampled only in IDLE.
- busy  out  1  high in START, RUN and REPORT.
- core_start  out  1  drives the core's start input.
- core_done  in  1  core's done output; level signal.
- result_valid  out  1  high in REPORT only.
- result_ack  in  1  host consumes result; sampled only in REPORT.
- cycle_count  out  CNT_WIDTH  latched RUN-cycle count of the last run.
- timed_out  out  1  latched; 1 if the last run hit MAX_CYCLES.
- run_count  out  8  completed runs (done or timeout); wraps 255→0.

## Operation
- States: IDLE, START, RUN, REPORT (2-bit encoding).
- IDLE: core_start=0, busy=0. req=1 → START; phase counter and cycle counter cleared to 0.
- START: core_start=1. Phase counter increments each cycle; after START_CYCLES cycles in START → RUN. core_done is ignored for completion here but still feeds the edge register.
- RUN: core_start=0. Completion is a rising edge of core_done: core_done=1 and done_q=0, where done_q is core_done registered every cycle in every state.
  - Edge seen: latch cycle_count = current counter value, timed_out=0, run_count+1 → REPORT.
  - No edge: counter+1. When the incremented value equals MAX_CYCLES, latch cycle_count=MAX_CYCLES, timed_out=1, run_count+1 → REPORT.
  - An edge and the timeout in the same cycle: the edge wins, timed_out=0.
- REPORT: result_valid=1; cycle_count and timed_out stable. result_ack=1 → IDLE in the next cycle. Outputs keep their latched values in IDLE until the next completion overwrites them.
- req outside IDLE is ignored, not queued. result_ack outside REPORT is ignored.
- A core_done level already high on entry to RUN does not complete the run. A core that never drops done ends in timeout; this is intended.
- Counter arithmetic is unsigned CNT_WIDTH with no wrap; the timeout stops it at MAX_CYCLES.

## Timing
- Reset values: state=IDLE, core_start=0, busy=0, result_valid=0, cycle_count=0, timed_out=0, run_count=0, done_q=0.
- Reset asserted mid-run forces IDLE immediately and asynchronously, with core_start=0. No result is produced and run_count is unchanged.
- req high at edge N: busy and core_start are high from N+1 through N+START_CYCLES. RUN starts at N+START_CYCLES+1.
- If the core_done rising edge is first visible in RUN cycle k (k=0 is the first RUN cycle), then cycle_count=k and result_valid rises at the next edge.
- result_ack high at edge M: result_valid=0 and busy=0 from M+1. A new req is accepted at edge M+1 at the earliest.
- All outputs are registered. The only combinational input-to-output path is none.

## Structure
- Package core_run_pkg holds the state enum (IDLE, START, RUN, REPORT), the default CNT_WIDTH, and the default MAX_CYCLES constants.
- There is no sub-module. The edge detect, phase counter and cycle counter are inline in a single always_ff with asynchronous reset, plus an always_comb for next-state logic.

## Test plan
- Basic run: START_CYCLES=2, req pulse, core_done rises in RUN cycle 5 → core_start high exactly 2 cycles, result_valid with cycle_count=5, timed_out=0, run_count=1.
- Timeout: MAX_CYCLES=8, core_done held 0 → REPORT after 8 RUN cycles, cycle_count=8, timed_out=1.
- Stale done: core_done held 1 throughout → no completion, timeout with cycle_count=MAX_CYCLES. Repeat with done pulsed only during START → still timeout.
- Coincident edge and timeout: MAX_CYCLES=4, done edge in RUN cycle 3 → cycle_count=3, timed_out=0.
- Handshake: req held high continuously with result_ack delayed 3 cycles → result_valid stays high and values stable. Exactly one new run starts at the cycle after ack. run_count wraps 255→0 after 256 runs.
- Async reset: reset asserted mid-RUN between clock edges → core_start, busy and result_valid go 0 immediately, and a subsequent req runs normally.
